// File: rtl/tt_pkg.sv
// rtl/tt_pkg.sv - shared types and helpers for the truth-table sweep capture block
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int CNT_W = 8;

    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// rtl/tt_settle_timer.sv - per-vector hold counter with terminal flag at cnt == SETTLE
module tt_settle_timer
    import tt_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic term
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(SETTLE);

    logic [CNT_W-1:0] cnt;

    assign term = (cnt == LIMIT);

    // Wraps to zero on the terminal cycle so the next vector gets a full window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= term ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tt_sweep_capture.sv
// rtl/tt_sweep_capture.sv - sweeps all input codes into a combinational DUT and captures its truth table
module tt_sweep_capture
    import tt_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [(1<<N_IN)-1:0]   expected,
    output logic [N_IN-1:0]        stim,
    input  logic                   resp,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   table_q,
    output logic                   match
);

    localparam int TW = tt_width(N_IN);
    localparam logic [N_IN-1:0] LAST_VEC = '1;

    state_t          state;
    logic [N_IN-1:0] vec;
    logic [TW-1:0]   exp_q;
    logic [TW-1:0]   table_next;
    logic            term;

    tt_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state != APPLY),
        .en    (state == APPLY),
        .term  (term)
    );

    // Table with the current sample merged in, so match sees the final bit.
    always_comb begin
        table_next      = table_q;
        table_next[vec] = resp;
    end

    assign stim = vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            vec     <= '0;
            exp_q   <= '0;
            table_q <= '0;
            match   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= APPLY;
                        vec     <= '0;
                        table_q <= '0;
                        match   <= 1'b0;
                        exp_q   <= expected;
                        busy    <= 1'b1;
                    end
                end
                APPLY: begin
                    if (term) begin
                        table_q <= table_next;
                        if (vec == LAST_VEC) begin
                            state <= DONE;
                            vec   <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            match <= (table_next == exp_q);
                        end else begin
                            vec <= vec + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
